// File: rtl/copro_pkg.sv
// Shared types and constants for the LM32 user-instruction coprocessor dispatcher.
// Holds the FSM state encoding, unit ids, opcode field positions and the FP error value.
package copro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int UNIT_ADD = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_DIV = 2;
  localparam int UNIT_CVT = 3;

  localparam int OPC_UNIT_MSB = 6;
  localparam int OPC_UNIT_LSB = 4;
  localparam int OPC_FUNC_MSB = 3;
  localparam int OPC_FUNC_LSB = 0;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/copro_dispatch.sv
// Issues one LM32 user instruction to one FP execution unit and returns its result,
// with illegal-unit detection and a per-operation timeout that flushes a hung unit.
module copro_dispatch
  import copro_pkg::*;
#(
  parameter int          NUM_UNITS      = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RESULT     = FP_QNAN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_valid,
  input  logic [10:0]             cpu_opcode,
  input  logic [31:0]             cpu_op0,
  input  logic [31:0]             cpu_op1,
  output logic [31:0]             cpu_result,
  output logic                    cpu_complete,
  output logic [NUM_UNITS-1:0]    unit_start,
  output logic [3:0]              unit_func,
  output logic [31:0]             unit_a,
  output logic [31:0]             unit_b,
  input  logic [NUM_UNITS-1:0]    unit_done,
  input  logic [32*NUM_UNITS-1:0] unit_result,
  output logic [NUM_UNITS-1:0]    unit_flush,
  output logic                    busy,
  output logic                    err_illegal,
  output logic                    err_timeout,
  input  logic                    err_clr
);

  localparam int          CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e          state_r;
  logic [2:0]      unit_sel_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      unit_id_s;
  logic            unit_legal_s;
  logic            done_sel_s;
  logic [31:0]     result_sel_s;

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [2:0] sel);
    logic [NUM_UNITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (3'(i) == sel) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // Decode the incoming unit id and select done/result of the unit in flight.
  always_comb begin
    unit_id_s    = cpu_opcode[OPC_UNIT_MSB:OPC_UNIT_LSB];
    unit_legal_s = ({1'b0, unit_id_s} < 4'(NUM_UNITS));
    done_sel_s   = 1'b0;
    result_sel_s = 32'h0000_0000;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (3'(i) == unit_sel_r) begin
        done_sel_s   = unit_done[i];
        result_sel_s = unit_result[32*i +: 32];
      end else begin
        done_sel_s   = done_sel_s;
        result_sel_s = result_sel_s;
      end
    end
  end

  // Dispatch FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      unit_sel_r   <= 3'd0;
      cnt_r        <= '0;
      cpu_result   <= 32'h0000_0000;
      cpu_complete <= 1'b0;
      unit_start   <= '0;
      unit_flush   <= '0;
      unit_func    <= 4'h0;
      unit_a       <= 32'h0000_0000;
      unit_b       <= 32'h0000_0000;
      busy         <= 1'b0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      cpu_complete <= 1'b0;
      unit_start   <= '0;
      unit_flush   <= '0;
      // Clear first so a same-cycle set below overrides it.
      if (err_clr) begin
        err_illegal <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (cpu_valid) begin
            unit_func <= cpu_opcode[OPC_FUNC_MSB:OPC_FUNC_LSB];
            unit_a    <= cpu_op0;
            unit_b    <= cpu_op1;
            if (unit_legal_s) begin
              unit_sel_r <= unit_id_s;
              unit_start <= unit_onehot(unit_id_s);
              busy       <= 1'b1;
              state_r    <= ISSUE;
            end else begin
              cpu_result   <= ERR_RESULT;
              cpu_complete <= 1'b1;
              err_illegal  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_r   <= '0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (done_sel_s) begin
            cpu_result   <= result_sel_s;
            cpu_complete <= 1'b1;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end else if (cnt_r == TO_LAST) begin
            unit_flush   <= unit_onehot(unit_sel_r);
            cpu_result   <= ERR_RESULT;
            cpu_complete <= 1'b1;
            err_timeout  <= 1'b1;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_copro_dispatch.sv
// Directed, table-driven bench for copro_dispatch with a behavioural unit responder.
module tb_copro_dispatch;

  localparam int NU = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_valid;
  logic [10:0]   cpu_opcode;
  logic [31:0]   cpu_op0, cpu_op1, cpu_result;
  logic          cpu_complete;
  logic [NU-1:0] unit_start, unit_done, unit_flush;
  logic [3:0]    unit_func;
  logic [31:0]   unit_a, unit_b;
  logic [32*NU-1:0] unit_result;
  logic          busy, err_illegal, err_timeout, err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  copro_dispatch #(.NUM_UNITS(NU), .TIMEOUT_CYCLES(TO), .ERR_RESULT(32'h7FC0_0000)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_opcode(cpu_opcode),
    .cpu_op0(cpu_op0), .cpu_op1(cpu_op1), .cpu_result(cpu_result),
    .cpu_complete(cpu_complete), .unit_start(unit_start), .unit_func(unit_func),
    .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done), .unit_result(unit_result),
    .unit_flush(unit_flush), .busy(busy), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  typedef struct {
    logic [10:0] opc;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;        // done in cycle 1+lat; 0 = never
    logic [31:0] data;
    int          stray_cyc;  // cycle for extra done pulses; 0 = none
    logic [3:0]  stray_mask;
    int          exp_cyc;
    logic [31:0] exp_res;
    logic [3:0]  exp_start;
    logic [3:0]  exp_flush;
    logic        exp_ill;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int  u;
    bit  seen;
    u = int'(v.opc[6:4]);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_opcode = v.opc; cpu_op0 = v.a; cpu_op1 = v.b;
    @(negedge clk);
    cpu_valid = 1'b0;
    chk({tag, " start"}, 32'(unit_start), 32'(v.exp_start));
    chk({tag, " busy1"}, 32'(busy), 32'(v.exp_start != 4'h0));
    chk({tag, " func"},  32'(unit_func), 32'(v.opc[3:0]));
    chk({tag, " a"}, unit_a, v.a);
    chk({tag, " b"}, unit_b, v.b);
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (cpu_complete) begin
        seen = 1'b1;
        unit_done = '0;
        chk({tag, " cycle"}, 32'(k), 32'(v.exp_cyc));
        chk({tag, " result"}, cpu_result, v.exp_res);
        chk({tag, " flush"}, 32'(unit_flush), 32'(v.exp_flush));
        chk({tag, " ill"}, 32'(err_illegal), 32'(v.exp_ill));
        chk({tag, " to"}, 32'(err_timeout), 32'(v.exp_to));
      end else begin
        unit_done = '0;
        if (v.lat > 0 && k == 1 + v.lat && u < NU) begin
          unit_done[u] = 1'b1;
          unit_result[32*u +: 32] = v.data;
        end
        if (k == v.stray_cyc) unit_done = unit_done | v.stray_mask;
      end
    end
    if (!seen) chk({tag, " complete_seen"}, 32'd0, 32'd1);
    @(negedge clk);
    unit_done = '0;
    chk({tag, " pulse"}, 32'(cpu_complete), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk({tag, " clr"}, 32'({err_illegal, err_timeout}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{11'h010, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4000_0000, 0, 4'h0,
                5, 32'h4000_0000, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{11'h070, 32'h1111_1111, 32'h2222_2222, 0, 32'h0, 0, 4'h0,
                1, 32'h7FC0_0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[2] = '{11'h025, 32'h3333_3333, 32'h4444_4444, 0, 32'h0, 0, 4'h0,
                10, 32'h7FC0_0000, 4'b0100, 4'b0100, 1'b0, 1'b1};
    vecs[3] = '{11'h026, 32'h5555_5555, 32'h6666_6666, 8, 32'h1234_5678, 0, 4'h0,
                10, 32'h1234_5678, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[4] = '{11'h03A, 32'h4049_0FDB, 32'h3F00_0000, 4, 32'hC049_0FDB, 3, 4'b0001,
                6, 32'hC049_0FDB, 4'b1000, 4'b0000, 1'b0, 1'b0};
    vecs[5] = '{11'h781, 32'hABCD_0001, 32'h0000_FFFF, 1, 32'h0BAD_F00D, 0, 4'h0,
                3, 32'h0BAD_F00D, 4'b0001, 4'b0000, 1'b0, 1'b0};
    vecs[6] = '{11'h01F, 32'h7777_7777, 32'h8888_8888, 2, 32'h4248_0000, 1, 4'b0010,
                4, 32'h4248_0000, 4'b0010, 4'b0000, 1'b0, 1'b0};

    rst_n = 1'b0; cpu_valid = 1'b0; cpu_opcode = 11'h000; cpu_op0 = 32'h0; cpu_op1 = 32'h0;
    unit_done = '0; err_clr = 1'b0;
    for (int i = 0; i < NU; i++) unit_result[32*i +: 32] = 32'hDEAD_0000 + 32'(i);
    repeat (2) @(negedge clk);
    chk("rst result", cpu_result, 32'h0);
    chk("rst ctl", 32'({cpu_complete, busy, err_illegal, err_timeout}), 32'd0);
    chk("rst unit", 32'({unit_start, unit_flush, unit_func}), 32'd0);
    chk("rst a", unit_a, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: valid held through the complete cycle starts the next op there.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_opcode = 11'h001; cpu_op0 = 32'hA1A1_A1A1; cpu_op1 = 32'hB1B1_B1B1;
    @(negedge clk);
    chk("b2b start1", 32'(unit_start), 32'b0001);
    cpu_opcode = 11'h012; cpu_op0 = 32'hA2A2_A2A2; cpu_op1 = 32'hB2B2_B2B2;
    @(negedge clk);
    unit_done = 4'b0001; unit_result[31:0] = 32'h1111_0001;
    @(negedge clk);
    unit_done = '0;
    chk("b2b cmp1", 32'(cpu_complete), 32'd1);
    chk("b2b res1", cpu_result, 32'h1111_0001);
    @(negedge clk);
    cpu_valid = 1'b0;
    chk("b2b start2", 32'(unit_start), 32'b0010);
    chk("b2b a2", unit_a, 32'hA2A2_A2A2);
    chk("b2b func2", 32'(unit_func), 32'd2);
    @(negedge clk);
    unit_done = 4'b0010; unit_result[63:32] = 32'h2222_0002;
    @(negedge clk);
    unit_done = '0;
    chk("b2b cmp2", 32'(cpu_complete), 32'd1);
    chk("b2b res2", cpu_result, 32'h2222_0002);
    @(negedge clk);

    // Async reset while waiting: outputs drop at once, op is lost silently.
    cpu_valid = 1'b1; cpu_opcode = 11'h020; cpu_op0 = 32'h5555_0000; cpu_op1 = 32'h6666_0000;
    @(negedge clk);
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-rst busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst result", cpu_result, 32'h0);
    chk("arst a", unit_a, 32'h0);
    chk("arst ctl", 32'({busy, cpu_complete, unit_start, unit_flush, unit_func}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int ev;
      ev = 0;
      repeat (12) begin
        @(negedge clk);
        if (cpu_complete || unit_flush != '0) ev++;
      end
      chk("arst quiet", 32'(ev), 32'd0);
    end
    run_op(vecs[0], "post-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
